// File: rtl/bus_transfer_ctrl.sv
// bus_transfer_ctrl
// Moves one 32-bit register to another over the shared bus, one move per request.
// A request latches source/destination indices in IDLE, drives the source onto the bus
// for one cycle (DRIVE), strobes the destination enable for one cycle (WRITE), then
// pulses done (DONE). Out-of-range indices skip straight to DONE with err set.
//
// Ports:
//   clock    - system clock, rising edge
//   clear    - asynchronous reset, active-low
//   start    - transfer request, sampled only in IDLE
//   src_sel  - source register index
//   dst_sel  - destination register index
//   reg_q    - packed register Q outputs, register i at [32*i+31:32*i]
//   busy     - high during DRIVE and WRITE
//   done     - one-cycle completion pulse
//   err      - one-cycle pulse with done for an invalid request
//   bus_out  - registered bus value feeding the register D inputs
//   reg_out  - one-hot source-drive strobe
//   reg_in   - one-hot destination write-enable
module bus_transfer_ctrl #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned SELW  = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic [SELW-1:0]       src_sel,
    input  logic [SELW-1:0]       dst_sel,
    input  logic [NREGS*32-1:0]   reg_q,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           bus_out,
    output logic [NREGS-1:0]      reg_out,
    output logic [NREGS-1:0]      reg_in
);

    typedef enum logic [1:0] {StIdle, StDrive, StWrite, StDone} state_e;

    localparam logic [SELW:0] RegLimit = (SELW + 1)'(NREGS);

    state_e           state_q, state_d;
    logic [SELW-1:0]  src_q, dst_q;
    logic             err_q;
    logic             req_bad;
    logic [31:0]      src_word;
    logic [NREGS-1:0] src_oh, dst_oh;

    // Either index outside the attached register range makes the request invalid.
    assign req_bad = ({1'b0, src_sel} >= RegLimit) || ({1'b0, dst_sel} >= RegLimit);

    // Decodes and the source mux work on latched indices only, so the outputs never
    // see the live select inputs.
    always_comb begin
        src_word = '0;
        src_oh   = '0;
        dst_oh   = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (src_q == SELW'(i)) begin
                src_word  = reg_q[32*i +: 32];
                src_oh[i] = 1'b1;
            end
            if (dst_q == SELW'(i)) begin
                dst_oh[i] = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = req_bad ? StDone : StDrive;
                end
            end
            StDrive: state_d = StWrite;
            StWrite: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Request latch, error flag and bus register
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            src_q   <= '0;
            dst_q   <= '0;
            err_q   <= 1'b0;
            bus_out <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        src_q <= src_sel;
                        dst_q <= dst_sel;
                        err_q <= req_bad;
                    end
                end
                // Sampled here so reg_q changes during WRITE cannot disturb the bus.
                StDrive: bus_out <= src_word;
                StDone:  err_q   <= 1'b0;
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        reg_out = '0;
        reg_in  = '0;
        unique case (state_q)
            StDrive: begin
                busy    = 1'b1;
                reg_out = src_oh;
            end
            StWrite: begin
                busy    = 1'b1;
                reg_out = src_oh;
                reg_in  = dst_oh;
            end
            StDone: begin
                done = 1'b1;
                err  = err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Testbench for bus_transfer_ctrl: directed moves with a scoreboard of expected
// transfers, popped by a monitor on each done pulse, plus direct checks for reset,
// abort and invalid requests on a 12-register instance.
module tb_bus_transfer_ctrl;

    typedef struct {
        logic [15:0] rout;
        logic [15:0] rin;
        logic [31:0] bus;
        int          done_cyc;
    } exp_t;

    logic         clock = 1'b0;
    logic         clear = 1'b1;
    logic         start = 1'b0;
    logic [3:0]   src_sel = '0;
    logic [3:0]   dst_sel = '0;
    logic [31:0]  regs [16];
    logic [511:0] reg_q;

    logic         busy, done, err;
    logic [31:0]  bus_out;
    logic [15:0]  reg_out, reg_in;

    logic         start2 = 1'b0;
    logic [3:0]   src2 = '0;
    logic [3:0]   dst2 = '0;
    logic         busy2, done2, err2;
    logic [31:0]  bus2;
    logic [11:0]  rout2, rin2;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb [$];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < 16; i++) reg_q[32*i +: 32] = regs[i];
    end

    bus_transfer_ctrl #(.NREGS(16), .SELW(4)) dut (
        .clock   (clock),
        .clear   (clear),
        .start   (start),
        .src_sel (src_sel),
        .dst_sel (dst_sel),
        .reg_q   (reg_q),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bus_out (bus_out),
        .reg_out (reg_out),
        .reg_in  (reg_in)
    );

    bus_transfer_ctrl #(.NREGS(12), .SELW(4)) dut12 (
        .clock   (clock),
        .clear   (clear),
        .start   (start2),
        .src_sel (src2),
        .dst_sel (dst2),
        .reg_q   (reg_q[383:0]),
        .busy    (busy2),
        .done    (done2),
        .err     (err2),
        .bus_out (bus2),
        .reg_out (rout2),
        .reg_in  (rin2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge just before the accepting edge: DONE shows 3 negedges later.
    task automatic push_exp(input int s, input int d, input logic [31:0] data);
        exp_t e;
        e.rout     = 16'(1) << s;
        e.rin      = 16'(1) << d;
        e.bus      = data;
        e.done_cyc = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic go(input int s, input int d, input logic [31:0] data);
        start   = 1'b1;
        src_sel = 4'(s);
        dst_sel = 4'(d);
        push_exp(s, d, data);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clock);
            k++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 0);
            sb.delete();
        end
        @(negedge clock);
    endtask

    // Monitor: accumulates what the DUT did during a transfer, compares on done.
    int          m_busy = 0;
    int          m_nrin = 0;
    logic [15:0] m_rout = '0;
    logic [15:0] m_rin = '0;
    logic [31:0] m_bus = '0;
    exp_t        m_e;

    always @(negedge clock) begin
        if (!clear) begin
            m_busy = 0; m_nrin = 0; m_rout = '0; m_rin = '0; m_bus = '0;
        end else begin
            check("reg_out_onehot", 32'($countones(reg_out) <= 1), 1);
            check("reg_in_onehot", 32'($countones(reg_in) <= 1), 1);
            if (busy) m_busy++;
            if (reg_out != 0 && m_rout == 0) m_rout = reg_out;
            if (reg_in != 0) begin
                m_rin = reg_in;
                m_bus = bus_out;
                m_nrin++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 0, 1);
                end else begin
                    m_e = sb.pop_front();
                    check("drive_reg_out", 32'(m_rout), 32'(m_e.rout));
                    check("write_reg_in", 32'(m_rin), 32'(m_e.rin));
                    check("write_bus_out", m_bus, m_e.bus);
                    check("err_valid", 32'(err), 0);
                    check("busy_cycles", 32'(m_busy), 2);
                    check("reg_in_cycles", 32'(m_nrin), 1);
                    check("done_cycle", 32'(cyc), 32'(m_e.done_cyc));
                end
                m_busy = 0; m_nrin = 0; m_rout = '0; m_rin = '0; m_bus = '0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 16; i++) regs[i] = 32'hA5A5_0000 | 32'(i);
        regs[3] = 32'hDEAD_BEEF;

        // Reset held with start asserted
        #1 clear = 1'b0;
        start = 1'b1; src_sel = 4'd3; dst_sel = 4'd7;
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_bus_out", bus_out, 0);
        check("rst_reg_out", 32'(reg_out), 0);
        check("rst_reg_in", 32'(reg_in), 0);
        start = 1'b0;
        clear = 1'b1;
        repeat (2) @(negedge clock);
        check("idle_busy", 32'(busy), 0);
        check("idle_done", 32'(done), 0);
        check("idle_reg_out", 32'(reg_out), 0);
        check("idle_reg_in", 32'(reg_in), 0);

        // Basic move R3 -> R7
        go(3, 7, 32'hDEAD_BEEF);
        drain();

        // Back-to-back with start held and selects changing every cycle
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            src_sel = 4'(i);
            dst_sel = 4'(15 - i);
            if (i % 4 == 0) push_exp(i, 15 - i, regs[i]);
            @(negedge clock);
        end
        start = 1'b0;
        drain();

        // Abort during DRIVE
        start = 1'b1; src_sel = 4'd2; dst_sel = 4'd9;
        @(posedge clock);
        #1 start = 1'b0;
        #1 clear = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_reg_out", 32'(reg_out), 0);
        check("abort_reg_in", 32'(reg_in), 0);
        check("abort_bus_out", bus_out, 0);
        check("abort_done", 32'(done), 0);
        repeat (3) begin
            @(negedge clock);
            check("abort_hold_reg_in", 32'(reg_in), 0);
        end
        clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_abort_reg_in", 32'(reg_in), 0);
            check("post_abort_busy", 32'(busy), 0);
        end
        go(3, 7, 32'hDEAD_BEEF);
        drain();

        // Self-move with reg_q changing during WRITE
        regs[5] = 32'h1234_5678;
        go(5, 5, 32'h1234_5678);
        @(posedge clock);
        #1 regs[5] = 32'h0;
        drain();

        // 12-register instance: a valid move, then out-of-range requests
        start2 = 1'b1; src2 = 4'd11; dst2 = 4'd0;
        @(negedge clock);
        start2 = 1'b0;
        k = 0;
        while (!done2 && k < 10) begin
            @(negedge clock);
            k++;
        end
        check("n12_valid_done", 32'(done2), 1);
        check("n12_valid_err", 32'(err2), 0);
        check("n12_valid_bus", bus2, regs[11]);
        @(negedge clock);
        for (int v = 0; v < 2; v++) begin
            start2 = 1'b1;
            src2 = (v == 0) ? 4'd13 : 4'd0;
            dst2 = (v == 0) ? 4'd2 : 4'd12;
            @(negedge clock);
            start2 = 1'b0;
            check("inv_done", 32'(done2), 1);
            check("inv_err", 32'(err2), 1);
            check("inv_busy", 32'(busy2), 0);
            check("inv_reg_out", 32'(rout2), 0);
            check("inv_reg_in", 32'(rin2), 0);
            check("inv_bus_out", bus2, regs[11]);
            @(negedge clock);
            check("inv_done_clear", 32'(done2), 0);
            check("inv_err_clear", 32'(err2), 0);
            check("inv_reg_in_after", 32'(rin2), 0);
            @(negedge clock);
        end

        check("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_transfer_ctrl.md
Name: bus_transfer_ctrl

Overview:
- Read-side counterpart of the register file's 32-bit bus-loaded registers: the registers are written from the bus, and this block selects one register's Q onto the bus and then strobes a destination register's enable.
- It performs one register-to-register move per request using a small FSM.
- It sits between the register file Q outputs and the shared bus. Its bus_out feeds the registers' D inputs, and its reg_in vector drives their enable inputs.

Parameters:
- NREGS, 16, number of registers attached; must be ≤ 2^SELW.
- SELW, 4, width of src_sel/dst_sel.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  asynchronous reset, active-low.
- start  input  1  request a transfer; sampled only in IDLE.
- src_sel  input  SELW  source register index.
- dst_sel  input  SELW  destination register index.
- reg_q  input  NREGS*32  packed register Q outputs; register i occupies bits [32*i+31:32*i].
- busy  output  1  high while a transfer is in progress (DRIVE, WRITE).
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle pulse coincident with done when the request was invalid.
- bus_out  output  32  registered bus value (BusMuxOut).
- reg_out  output  NREGS  one-hot source-drive strobe (Rout).
- reg_in  output  NREGS  one-hot destination write-enable (Rin), connected to the register enables.

Behaviour:
- Reset (clear=0, asynchronous): state=IDLE; bus_out=0, reg_out=0, reg_in=0, busy=0, done=0, err=0; latched src/dst=0.
- Reset mid-transfer aborts immediately. No reg_in pulse may follow. After clear is released the block sits in IDLE.
- All outputs are decoded from flops only; there is no combinational path from start, src_sel or dst_sel to any output.
- States: IDLE, DRIVE, WRITE, DONE.
- IDLE:
  - Outputs: busy=0, done=0, reg_out=0, reg_in=0; bus_out holds its last value.
  - On a clock edge with start=1: latch src_sel/dst_sel.
  - If either latched index ≥ NREGS, go to DONE with the error flag set.
  - Otherwise go to DRIVE.
- DRIVE (1 cycle):
  - busy=1; reg_out = one-hot(src); reg_in=0.
  - At the edge ending DRIVE, bus_out <= reg_q slice[src]; go to WRITE.
- WRITE (1 cycle):
  - busy=1; reg_out = one-hot(src) (still driving); reg_in = one-hot(dst); bus_out stable.
  - The destination register captures bus_out on the edge ending WRITE. Go to DONE.
- DONE (1 cycle):
  - done=1, busy=0, reg_out=0, reg_in=0.
  - err=1 only for an invalid request; the error flag clears on leaving DONE.
  - Always go to IDLE; start is ignored in DONE.
- Latency: start accepted at edge N → DRIVE in cycle N+1, WRITE in N+2, DONE in N+3. The next start can be accepted at edge N+4. Throughput is one transfer per 4 cycles.
- Invalid request: IDLE→DONE directly, with done=1 and err=1 together in cycle N+1. No reg_out or reg_in strobe occurs and bus_out is unchanged.
- src==dst is legal: the register is rewritten with its own value, with normal timing.
- start held high continuously: a new transfer starts each time IDLE is re-entered. Latched src/dst take the values present at that edge.
- Changes on src_sel/dst_sel while busy have no effect.
- reg_q changing during WRITE does not alter bus_out, because bus_out was sampled at the end of DRIVE.
- reg_in is never asserted outside WRITE. At most one bit of reg_out and at most one bit of reg_in is high at any time.

Test Plan:
- Reset: hold clear=0 with start=1 → all outputs 0. Release clear → still IDLE, nothing asserted until start is sampled.
- Basic move: reg_q[R3]=0xDEADBEEF; start with src=3, dst=7 → cycle N+1 reg_out=0x0008; cycle N+2 bus_out=0xDEADBEEF, reg_in=0x0080; cycle N+3 done=1, err=0; busy high for exactly 2 cycles.
- Invalid index: override NREGS=12; start with src=13, dst=2 → done=1 and err=1 at N+1; reg_out and reg_in never set; bus_out unchanged.
- Back-to-back: start held high, src/dst changed each cycle → transfers at 4-cycle spacing. Each transfer uses the src/dst present at its accepting edge. No overlapping strobes.
- Abort: assert clear=0 during DRIVE → outputs 0 asynchronously. No reg_in pulse ever follows; the next start behaves as in the basic-move case.
- Self-move and stability: src=dst=5, reg_q[R5]=0x12345678. Change reg_q[R5] to 0 during WRITE → bus_out stays 0x12345678 through WRITE; reg_in=0x0020.
